// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM fade sequencer: default sizes, hold-counter
// width and the sequencer state encoding.
package pwm_seq_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DUTY_W_DEF = 10;
  localparam int HOLD_W     = 16;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_RAMP_UP   = 3'd1;
  localparam seq_state_t ST_HOLD_HI   = 3'd2;
  localparam seq_state_t ST_RAMP_DOWN = 3'd3;
  localparam seq_state_t ST_HOLD_LO   = 3'd4;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter: counts 0..period and wraps, flagging tick
// in the cycle the count equals period.
module pwm_period_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign tick = (cnt_q == period);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Fades masked LED channels one at a time: ramp up, dwell at the ceiling,
// ramp down, dwell at zero, then move on to the next masked channel.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int DUTY_W = DUTY_W_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [31:0]              period,
  input  logic [DUTY_W-1:0]        step,
  input  logic [DUTY_W-1:0]        max_duty,
  input  logic [HOLD_W-1:0]        hold_periods,
  input  logic [NUM_CH-1:0]        ch_mask,
  output logic [NUM_CH*DUTY_W-1:0] duty_cycle,
  output logic [NUM_CH-1:0]        en,
  output logic                     period_tick,
  output logic [CH_W-1:0]          active_ch,
  output logic                     busy,
  output logic                     cycle_done,
  output logic [2:0]               state_dbg
);

  seq_state_t          state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                cycle_done_q, cycle_done_d;
  logic [31:0]         period_l_q, period_l_d;
  logic [DUTY_W-1:0]   step_l_q, step_l_d;
  logic [DUTY_W-1:0]   max_l_q, max_l_d;
  logic [HOLD_W-1:0]   hold_l_q, hold_l_d;
  logic [NUM_CH-1:0]   mask_l_q, mask_l_d;

  logic                tick_raw;
  logic                tick;
  logic [DUTY_W-1:0]   eff_step;
  logic [DUTY_W:0]     up_sum;
  logic [CH_W-1:0]     start_ch;
  logic [CH_W-1:0]     wrap_ch;
  logic [CH_W-1:0]     next_ch;
  logic                wrap;

  // The counter is held at zero while idle so the first period after start is full length.
  pwm_period_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (stop || (state_q == ST_IDLE)),
    .period (period_l_q),
    .tick   (tick_raw)
  );

  assign busy        = (state_q != ST_IDLE);
  assign tick        = tick_raw && busy;
  assign period_tick = tick;
  assign active_ch   = ch_q;
  assign cycle_done  = cycle_done_q;
  assign state_dbg   = state_q;

  assign eff_step = (step_l_q == '0) ? DUTY_W'(1) : step_l_q;
  assign up_sum   = {1'b0, duty_q} + {1'b0, eff_step};

  // Lowest set bit of the live mask (for start) and of the latched mask (for wrap),
  // plus the next latched bit above the current channel.
  always_comb begin
    start_ch = '0;
    wrap_ch  = '0;
    next_ch  = '0;
    wrap     = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) start_ch = CH_W'(i);
      if (mask_l_q[i]) wrap_ch = CH_W'(i);
    end
    next_ch = wrap_ch;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_l_q[i] && (CH_W'(i) > ch_q)) begin
        next_ch = CH_W'(i);
        wrap    = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    ch_d         = ch_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_done_d = 1'b0;
    period_l_d   = period_l_q;
    step_l_d     = step_l_q;
    max_l_d      = max_l_q;
    hold_l_d     = hold_l_q;
    mask_l_d     = mask_l_q;
    if (stop) begin
      state_d    = ST_IDLE;
      duty_d     = '0;
      ch_d       = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (ch_mask != '0)) begin
            period_l_d = period;
            step_l_d   = step;
            max_l_d    = max_duty;
            hold_l_d   = hold_periods;
            mask_l_d   = ch_mask;
            ch_d       = start_ch;
            duty_d     = '0;
            hold_cnt_d = '0;
            state_d    = ST_RAMP_UP;
          end
        end
        ST_RAMP_UP: begin
          if (tick) begin
            if (up_sum >= {1'b0, max_l_q}) begin
              duty_d  = max_l_q;
              state_d = ST_HOLD_HI;
            end else begin
              duty_d = up_sum[DUTY_W-1:0];
            end
          end
        end
        ST_HOLD_HI: begin
          if (tick) begin
            if (hold_cnt_q == hold_l_q) begin
              hold_cnt_d = '0;
              state_d    = ST_RAMP_DOWN;
            end else begin
              hold_cnt_d = hold_cnt_q + 16'd1;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (tick) begin
            if (duty_q <= eff_step) begin
              duty_d  = '0;
              state_d = ST_HOLD_LO;
            end else begin
              duty_d = duty_q - eff_step;
            end
          end
        end
        ST_HOLD_LO: begin
          if (tick) begin
            if (hold_cnt_q == hold_l_q) begin
              hold_cnt_d   = '0;
              ch_d         = next_ch;
              cycle_done_d = wrap;
              state_d      = ST_RAMP_UP;
            end else begin
              hold_cnt_d = hold_cnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    en         = '0;
    duty_cycle = '0;
    if (busy) begin
      en[ch_q] = 1'b1;
      duty_cycle[int'(ch_q)*DUTY_W +: DUTY_W] = duty_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      duty_q       <= '0;
      ch_q         <= '0;
      hold_cnt_q   <= '0;
      cycle_done_q <= 1'b0;
      period_l_q   <= '0;
      step_l_q     <= '0;
      max_l_q      <= '0;
      hold_l_q     <= '0;
      mask_l_q     <= '0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      ch_q         <= ch_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_done_q <= cycle_done_d;
      period_l_q   <= period_l_d;
      step_l_q     <= step_l_d;
      max_l_q      <= max_l_d;
      hold_l_q     <= hold_l_d;
      mask_l_q     <= mask_l_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed scenarios plus randomized configs, each
// checked tick by tick against a per-channel fade profile built from the rules.
module tb_pwm_fade_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] period;
  logic [9:0]  step;
  logic [9:0]  max_duty;
  logic [15:0] hold_periods;
  logic [3:0]  ch_mask;
  logic [39:0] duty_cycle;
  logic [3:0]  en;
  logic        period_tick;
  logic [1:0]  active_ch;
  logic        busy;
  logic        cycle_done;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  pwm_fade_sequencer #(.NUM_CH(4), .DUTY_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .period       (period),
    .step         (step),
    .max_duty     (max_duty),
    .hold_periods (hold_periods),
    .ch_mask      (ch_mask),
    .duty_cycle   (duty_cycle),
    .en           (en),
    .period_tick  (period_tick),
    .active_ch    (active_ch),
    .busy         (busy),
    .cycle_done   (cycle_done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  function automatic logic [63:0] obs_pack();
    return {16'b0, busy, cycle_done, active_ch, en, duty_cycle};
  endfunction

  function automatic logic [63:0] pack_exp(input int d, input int ch, input bit cd);
    logic [39:0] dc;
    logic [3:0]  e;
    logic [1:0]  c2;
    dc = '0;
    e  = '0;
    c2 = 2'(ch);
    dc[ch*10 +: 10] = 10'(d);
    e[ch] = 1'b1;
    return {16'b0, 1'b1, cd, c2, e, dc};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected post-tick outputs: for each masked channel in ascending order,
  // ramp up to the ceiling, dwell hold+1 ticks, ramp down to 0, dwell, advance.
  task automatic build_model(input int stp, input int mx, input int hld,
                             input logic [3:0] msk, input int n);
    int chs[$];
    int s;
    int d;
    int k;
    exp_q.delete();
    for (int i = 0; i < 4; i++) if (msk[i]) chs.push_back(i);
    s = (stp == 0) ? 1 : stp;
    k = 0;
    while (exp_q.size() < n) begin
      d = 0;
      do begin
        d = (d + s > mx) ? mx : d + s;
        exp_q.push_back(pack_exp(d, chs[k], 1'b0));
      end while (d != mx);
      for (int h = 0; h <= hld; h++) exp_q.push_back(pack_exp(mx, chs[k], 1'b0));
      do begin
        d = (d > s) ? d - s : 0;
        exp_q.push_back(pack_exp(d, chs[k], 1'b0));
      end while (d != 0);
      for (int h = 0; h < hld; h++) exp_q.push_back(pack_exp(0, chs[k], 1'b0));
      if (k + 1 == chs.size()) begin
        k = 0;
        exp_q.push_back(pack_exp(0, chs[0], 1'b1));
      end else begin
        k++;
        exp_q.push_back(pack_exp(0, chs[k], 1'b0));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int per, input int stp, input int mx, input int hld,
                          input logic [3:0] msk, input int n);
    build_model(stp, mx, hld, msk, n);
    @(negedge clk);
    period       = 32'(per);
    step         = 10'(stp);
    max_duty     = 10'(mx);
    hold_periods = 16'(hld);
    ch_mask      = msk;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    // Config changes while busy must not matter.
    period       = $urandom;
    step         = 10'($urandom);
    max_duty     = 10'($urandom);
    hold_periods = 16'($urandom);
    ch_mask      = 4'($urandom);
  endtask

  task automatic wait_tick(input int per);
    int c;
    c = 0;
    while (period_tick !== 1'b1 && c <= per + 2) begin
      @(negedge clk);
      start = 1'b0;
      c++;
    end
    check("tick_gap", 64'(c), 64'(per));
  endtask

  task automatic run_ticks(input int n, input int per, input int poke_k);
    logic [63:0] e;
    for (int k = 0; k < n; k++) begin
      wait_tick(per);
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      check("post_tick", obs_pack(), e);
      if (k == poke_k) begin
        start   = 1'b1;
        ch_mask = 4'($urandom_range(1, 15));
      end
    end
  endtask

  task automatic do_stop(input string tag);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check(tag, obs_pack(), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int per, stp, mx, hld, pk;
    logic [3:0] msk;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    period = '0; step = '0; max_duty = '0; hold_periods = '0; ch_mask = '0;

    @(negedge clk);
    check("reset_outputs", obs_pack(), 64'd0);
    check("reset_tick", 64'(period_tick), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", obs_pack(), 64'd0);

    // Basic fade on ch0, tick every 4 clocks.
    do_start(3, 100, 300, 1, 4'b0001, 10);
    run_ticks(10, 3, -1);
    do_stop("stop_basic");

    // Saturation at the ceiling.
    do_start(1, 200, 300, 0, 4'b0001, 4);
    run_ticks(4, 1, -1);
    do_stop("stop_sat");

    // Two channels with wrap; start pulse while busy must be ignored.
    do_start(0, 150, 300, 0, 4'b1010, 14);
    run_ticks(14, 0, 5);
    do_stop("stop_mask");

    // Start with an empty mask.
    @(negedge clk);
    ch_mask = 4'b0000;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    check("empty_mask_start", obs_pack(), 64'd0);
    repeat (3) @(negedge clk);
    check("empty_mask_stay", obs_pack(), 64'd0);

    // Stop coinciding with a tick during ramp up.
    do_start(2, 10, 500, 0, 4'b0100, 2);
    run_ticks(1, 2, -1);
    wait_tick(2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_on_tick", obs_pack(), 64'd0);
    check("stop_on_tick_ptick", 64'(period_tick), 64'd0);
    repeat (4) @(negedge clk);
    check("stop_stays_idle", obs_pack(), 64'd0);

    // Asynchronous reset during the high dwell.
    do_start(1, 500, 500, 20, 4'b0001, 3);
    run_ticks(3, 1, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", obs_pack(), 64'd0);
    check("async_reset_tick", 64'(period_tick), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", obs_pack(), 64'd0);
    do_start(0, 512, 300, 0, 4'b0010, 3);
    run_ticks(3, 0, -1);
    do_stop("stop_after_reset");

    // Randomized configurations.
    for (int it = 0; it < 6; it++) begin
      per = $urandom_range(0, 3);
      stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 400);
      mx  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 1023);
      hld = $urandom_range(0, 2);
      msk = 4'($urandom_range(1, 15));
      pk  = $urandom_range(0, 14);
      do_start(per, stp, mx, hld, msk, 16);
      run_ticks(16, per, pk);
      do_stop("stop_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of LED channels it sequences.
REQ-002 The block SHALL have parameter DUTY_W, default 10, meaning the duty-cycle width of each channel.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins the sequence.
REQ-006 The block SHALL have port stop, input, 1 bit: a one-cycle pulse that aborts the sequence.
REQ-007 The block SHALL have port period, input, 32 bits: PWM period length minus 1, in clocks.
REQ-008 The block SHALL have port step, input, DUTY_W bits: duty increment/decrement per period.
REQ-009 The block SHALL have port max_duty, input, DUTY_W bits: the ramp ceiling.
REQ-010 The block SHALL have port hold_periods, input, 16 bits: dwell length, in periods, at the ceiling and at zero.
REQ-011 The block SHALL have port ch_mask, input, NUM_CH bits: the channels that take part in the sequence.
REQ-012 The block SHALL have port duty_cycle, output, NUM_CH*DUTY_W bits: per-channel duty, with channel i at bits [i*DUTY_W +: DUTY_W].
REQ-013 The block SHALL have port en, output, NUM_CH bits: per-channel PWM enable.
REQ-014 The block SHALL have port period_tick, output, 1 bit: a one-cycle pulse at the end of each PWM period.
REQ-015 The block SHALL have port active_ch, output, clog2(NUM_CH) bits: the channel currently being faded.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port cycle_done, output, 1 bit: a one-cycle pulse each time the sequence wraps back to the first masked channel.

Function
REQ-018 The period counter SHALL count 0..period_l, where period_l is the latched period, then wrap to 0; period_tick SHALL be high in the cycle the counter equals period_l, so period_l=0 gives a tick every clock.
REQ-019 On start while in IDLE with ch_mask!=0, the block SHALL latch period, step, max_duty, hold_periods and ch_mask, clear the counter, select the lowest set mask bit and enter RAMP_UP on the next cycle.
REQ-020 The block SHALL ignore start when ch_mask==0, and SHALL ignore start while busy.
REQ-021 The FSM SHALL have the states IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN and HOLD_LO, and SHALL change duty or state only on period_tick.
REQ-022 In RAMP_UP, each tick SHALL set duty = min(duty+step, max_duty), computed DUTY_W+1 bits wide with no wrap; the tick on which duty reaches max_duty SHALL move the FSM to HOLD_HI.
REQ-023 In HOLD_HI, the block SHALL count hold_periods ticks and then enter RAMP_DOWN; hold_periods=0 SHALL make the transition on the next tick.
REQ-024 In RAMP_DOWN, each tick SHALL set duty = max(duty-step, 0) with no underflow; duty reaching 0 SHALL move the FSM to HOLD_LO.
REQ-025 HOLD_LO SHALL behave like HOLD_HI; on exit, the block SHALL advance active_ch to the next set mask bit, wrapping to the lowest set bit and pulsing cycle_done on the wrap, and SHALL enter RAMP_UP.
REQ-026 step=0 or max_duty=0 SHALL be treated as a duty step of 1 for step=0, and as an immediate ceiling for max_duty=0, so the FSM never stalls.
REQ-027 en[active_ch] SHALL be 1 while busy; every other en bit and duty field SHALL be 0.
REQ-028 stop SHALL force IDLE on the next clock from any state, with all duty fields 0 and en=0; stop SHALL take priority over a simultaneous start or tick.
REQ-029 Config input changes while busy SHALL have no effect until the next start.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with duty_cycle=0, en=0, period_tick=0, active_ch=0, busy=0, cycle_done=0, the counters at 0 and the latched config at 0.
REQ-031 Reset asserted mid-sequence SHALL take effect immediately (asynchronously); deassertion SHALL leave the block in IDLE awaiting start.

Structure
REQ-032 A shared package pwm_seq_pkg SHALL hold the FSM state enum, NUM_CH and DUTY_W defaults, and the hold-counter width of 16.
REQ-033 The period counter and tick generator SHALL be a separate sub-module, pwm_period_timer, with inputs clk, rst_n, clear and period and output tick.
REQ-034 The PWM output stage SHALL stay outside this block; duty_cycle, en and period connect to it.

Verification
REQ-035 A bench SHALL cover: period=3, step=100, max_duty=300, hold=1, mask=0001, start -> ch0 duty sequence 100, 200, 300 (then held), 200, 100, 0 on successive ticks, with a tick every 4 clocks.
REQ-036 A bench SHALL cover: step=200, max_duty=300 -> duty goes 200 then 300 (saturated, not 400).
REQ-037 A bench SHALL cover: mask=1010 -> active_ch goes 1 then 3, then wraps to 1 with a single cycle_done pulse; en is one-hot on the active channel only.
REQ-038 A bench SHALL cover: stop in the same cycle as period_tick during RAMP_UP -> next clock busy=0, en=0000, all duties 0.
REQ-039 A bench SHALL cover: rst_n pulled low mid-HOLD_HI -> all outputs 0 with no clock edge, and IDLE after release.
REQ-040 A bench SHALL cover: start with mask=0000, and start while busy -> no state change.
